bram_dp: RTL and testbench
==========================

BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 Parameter ADDRESS_BITS, default 8, word address width; depth MEM_SIZE = 2**ADDRESS_BITS.
REQ-002 Parameter DATA_BITS, default 32, word width; SHALL be a multiple of 8; NB = DATA_BITS/8 byte lanes.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_en_a  input  1  port A access enable (read or write).
REQ-006 i_we_a  input  NB  port A byte write enables; bit k covers data bits [8k+7:8k].
REQ-007 i_addr_a  input  ADDRESS_BITS  port A word address.
REQ-008 i_data_a  input  DATA_BITS  port A write data.
REQ-009 o_data_a  output  DATA_BITS  port A read data.
REQ-010 i_en_b  input  1  port B read enable (read-only port, debug/fetch use).
REQ-011 i_addr_b  input  ADDRESS_BITS  port B word address.
REQ-012 o_data_b  output  DATA_BITS  port B read data.
REQ-013 o_busy  output  1  high while memory clear sequence is active; ports ignored.

Function
REQ-014 Storage: MEM_SIZE x DATA_BITS array, written only via port A or clear sequence.
REQ-015 Port A write: on rising edge with i_en_a=1, o_busy=0, each lane k with i_we_a[k]=1 updated; other lanes keep old value.
REQ-016 Port A read: on rising edge with i_en_a=1, o_busy=0, o_data_a loads mem[i_addr_a] pre-write value (read-first), including when i_we_a != 0.
REQ-017 Port B read: on rising edge with i_en_b=1, o_busy=0, o_data_b loads mem[i_addr_b]; same-address same-cycle port A write returns old word on B (read-first).
REQ-018 Read latency 1 cycle (macro off); data held while enable low.
REQ-019 Enable low on a port: no write, output register holds previous value.
REQ-020 Clear FSM states CLEAR, READY; counter clr_addr of ADDRESS_BITS bits.
REQ-021 CLEAR: each cycle writes all-zero word to mem[clr_addr], increments clr_addr; when clr_addr = MEM_SIZE-1 is written, next state READY.
REQ-022 o_busy = 1 in CLEAR, 0 in READY; clear takes exactly MEM_SIZE cycles after rst deasserts.
REQ-023 During CLEAR, port enables ignored; o_data_a, o_data_b held at 0.
REQ-024 READY persists until rst; no other transition.

Reset
REQ-025 While rst=1 at a rising edge: state=CLEAR, clr_addr=0, o_data_a=0, o_data_b=0, o_busy=1, pipeline regs=0.
REQ-026 rst asserted mid-clear or mid-operation restarts clear from address 0; no port writes performed on that edge.

Configuration
REQ-027 Macro BRAM_DP_OUTREG_EN defined: extra output register stage on both ports; read latency 2; stage advances every cycle, reset to 0, held at 0 during CLEAR.
REQ-028 Macro BRAM_DP_OUTREG_EN undefined: single register stage, latency 1 per REQ-018; all other behaviour identical.

Verification
REQ-029 Release rst, count cycles -> o_busy high exactly 256 cycles (defaults), then low; read addr 0x00 and 0xFF on B -> 0x00000000.
REQ-030 A write addr 0x10 data 0xDEADBEEF we=4'hF, then we=4'b0101 data 0x11223344 -> read 0x10 gives 0xDE22BE44.
REQ-031 Same cycle A write 0xCAFEF00D to 0x20 (old 0x0), B read 0x20 -> o_data_b=0x00000000; next B read -> 0xCAFEF00D.
REQ-032 A read addr 0x30 with en, then en low with addr changed -> o_data_a unchanged; latency 1 (2 with BRAM_DP_OUTREG_EN).
REQ-033 Assert rst for 1 cycle at clear cycle 100 after writing data -> o_busy restarts, full 256-cycle clear, all locations read 0.
REQ-034 Ports driven with en=1, we=4'hF during CLEAR -> no effect, outputs 0, post-clear memory all 0.

Source files
------------

// File: rtl/bram_dp.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only,
// zero-fill after reset. Define BRAM_DP_OUTREG_EN for an extra output register stage.
module bram_dp #(
   parameter int ADDRESS_BITS = 8,
   parameter int DATA_BITS    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en_a,
   input  logic [DATA_BITS/8-1:0]  i_we_a,
   input  logic [ADDRESS_BITS-1:0] i_addr_a,
   input  logic [DATA_BITS-1:0]    i_data_a,
   output logic [DATA_BITS-1:0]    o_data_a,
   input  logic                    i_en_b,
   input  logic [ADDRESS_BITS-1:0] i_addr_b,
   output logic [DATA_BITS-1:0]    o_data_b,
   output logic                    o_busy
);

   localparam int MEM_SIZE = 2 ** ADDRESS_BITS;
   localparam int NB       = DATA_BITS / 8;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  r_state;
   logic [ADDRESS_BITS-1:0] r_clr_addr;
   logic                    r_busy;
   logic [DATA_BITS-1:0]    r_mem [MEM_SIZE];
   logic [DATA_BITS-1:0]    r_rd_a;
   logic [DATA_BITS-1:0]    r_rd_b;
   logic                    w_ready;
   logic                    w_clr_last;

   assign w_ready    = (r_state == READY);
   assign w_clr_last = (r_clr_addr == {ADDRESS_BITS{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= CLEAR;
         r_clr_addr <= '0;
         r_busy     <= 1'b1;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (w_clr_last) begin
                  r_state <= READY;
                  r_busy  <= 1'b0;
               end
            end
            READY: begin
               r_state <= READY;
            end
            default: begin
               r_state <= CLEAR;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage has no reset so it maps to block RAM; one write source per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!w_ready) begin
            r_mem[r_clr_addr] <= '0;
         end else if (i_en_a) begin
            for (int k = 0; k < NB; k++) begin
               if (i_we_a[k]) begin
                  r_mem[i_addr_a][8*k +: 8] <= i_data_a[8*k +: 8];
               end
            end
         end
      end
   end

   // Read-first: nonblocking reads see the word before this edge's write.
   always_ff @(posedge clk) begin
      if (rst || !w_ready) begin
         r_rd_a <= '0;
         r_rd_b <= '0;
      end else begin
         if (i_en_a) begin
            r_rd_a <= r_mem[i_addr_a];
         end
         if (i_en_b) begin
            r_rd_b <= r_mem[i_addr_b];
         end
      end
   end

`ifdef BRAM_DP_OUTREG_EN
   logic [DATA_BITS-1:0] r_out_a;
   logic [DATA_BITS-1:0] r_out_b;

   always_ff @(posedge clk) begin
      if (rst || !w_ready) begin
         r_out_a <= '0;
         r_out_b <= '0;
      end else begin
         r_out_a <= r_rd_a;
         r_out_b <= r_rd_b;
      end
   end

   assign o_data_a = r_out_a;
   assign o_data_b = r_out_b;
`else
   assign o_data_a = r_rd_a;
   assign o_data_b = r_rd_b;
`endif

   assign o_busy = r_busy;

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench for bram_dp: clear sequence, byte-lane writes, read-first,
// hold-on-disable, latency and reset-during-clear.
module tb_bram_dp;

   logic        clk;
   logic        rst;
   logic        i_en_a;
   logic [3:0]  i_we_a;
   logic [7:0]  i_addr_a;
   logic [31:0] i_data_a;
   logic [31:0] o_data_a;
   logic        i_en_b;
   logic [7:0]  i_addr_b;
   logic [31:0] o_data_b;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        en_a;
      logic [3:0]  we_a;
      logic [7:0]  addr_a;
      logic [31:0] data_a;
      logic        en_b;
      logic [7:0]  addr_b;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   vec_t vecs [12];

   bram_dp #(.ADDRESS_BITS(8), .DATA_BITS(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_en_a   (i_en_a),
      .i_we_a   (i_we_a),
      .i_addr_a (i_addr_a),
      .i_data_a (i_data_a),
      .o_data_a (o_data_a),
      .i_en_b   (i_en_b),
      .i_addr_b (i_addr_b),
      .o_data_b (o_data_b),
      .o_busy   (o_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // After the capturing edge, the registered output needs one more edge.
   task automatic settle();
      tick();
`ifdef BRAM_DP_OUTREG_EN
      i_en_a = 1'b0;
      i_en_b = 1'b0;
      tick();
`endif
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_junk();
      i_en_a   = 1'b1;
      i_we_a   = 4'hF;
      i_addr_a = 8'($urandom_range(0, 255));
      i_data_a = $urandom;
      i_en_b   = 1'b1;
      i_addr_b = 8'($urandom_range(0, 255));
   endtask

   task automatic run_clear(input string tag);
      int n;
      int bad;
      n   = 0;
      bad = 0;
      while (o_busy === 1'b1 && n < 1000) begin
         drive_junk();
         tick();
         n++;
         if (o_busy === 1'b1 && (o_data_a !== 32'h0 || o_data_b !== 32'h0)) bad++;
      end
      i_en_a = 1'b0;
      i_en_b = 1'b0;
      i_we_a = 4'h0;
      check({tag, "_clear_len"}, 32'(n), 32'd256);
      check({tag, "_clear_out_zero"}, 32'(bad), 32'd0);
      check({tag, "_busy_low"}, {31'b0, o_busy}, 32'd0);
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 256; i++) begin
         i_en_a   = 1'b1;
         i_we_a   = 4'h0;
         i_addr_a = 8'(i);
         i_en_b   = 1'b1;
         i_addr_b = 8'(255 - i);
         settle();
         check({tag, "_zero_a"}, o_data_a, 32'h0);
         check({tag, "_zero_b"}, o_data_b, 32'h0);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h00000000, 32'h00000000};
      vecs[1]  = '{1'b1, 4'h5, 8'h10, 32'h11223344, 1'b0, 8'h00, 32'hDEADBEEF, 32'h00000000};
      vecs[2]  = '{1'b1, 4'h0, 8'h10, 32'h00000000, 1'b1, 8'h10, 32'hDE22BE44, 32'hDE22BE44};
      vecs[3]  = '{1'b1, 4'hF, 8'h20, 32'hCAFEF00D, 1'b1, 8'h20, 32'h00000000, 32'h00000000};
      vecs[4]  = '{1'b1, 4'h0, 8'h30, 32'h00000000, 1'b1, 8'h20, 32'h00000000, 32'hCAFEF00D};
      vecs[5]  = '{1'b1, 4'hF, 8'h30, 32'h12345678, 1'b0, 8'h20, 32'h00000000, 32'hCAFEF00D};
      vecs[6]  = '{1'b1, 4'h0, 8'h30, 32'h00000000, 1'b1, 8'h00, 32'h12345678, 32'h00000000};
      vecs[7]  = '{1'b0, 4'hF, 8'h10, 32'hFFFFFFFF, 1'b0, 8'h10, 32'h12345678, 32'h00000000};
      vecs[8]  = '{1'b1, 4'h0, 8'h10, 32'h00000000, 1'b1, 8'hFF, 32'hDE22BE44, 32'h00000000};
      vecs[9]  = '{1'b1, 4'h8, 8'h40, 32'hAA000000, 1'b0, 8'h40, 32'h00000000, 32'h00000000};
      vecs[10] = '{1'b1, 4'h2, 8'h40, 32'h0000BB00, 1'b1, 8'h40, 32'hAA000000, 32'hAA000000};
      vecs[11] = '{1'b1, 4'h0, 8'h40, 32'h00000000, 1'b1, 8'h40, 32'hAA00BB00, 32'hAA00BB00};

      rst = 1'b1;
      drive_junk();
      repeat (3) tick();
      check("rst_busy", {31'b0, o_busy}, 32'd1);
      check("rst_data_a", o_data_a, 32'h0);
      check("rst_data_b", o_data_b, 32'h0);

      rst = 1'b0;
      run_clear("init");
      read_all_zero("init");

      for (int v = 0; v < 12; v++) begin
         i_en_a   = vecs[v].en_a;
         i_we_a   = vecs[v].we_a;
         i_addr_a = vecs[v].addr_a;
         i_data_a = vecs[v].data_a;
         i_en_b   = vecs[v].en_b;
         i_addr_b = vecs[v].addr_b;
         settle();
         check($sformatf("vec%0d_a", v), o_data_a, vecs[v].exp_a);
         check($sformatf("vec%0d_b", v), o_data_b, vecs[v].exp_b);
      end

      // Latency: output currently 0xAA00BB00, word at 0x10 is 0xDE22BE44.
      i_en_a   = 1'b1;
      i_we_a   = 4'h0;
      i_addr_a = 8'h10;
      tick();
      i_en_a   = 1'b0;
      i_addr_a = 8'h40;
`ifdef BRAM_DP_OUTREG_EN
      check("lat_first_edge", o_data_a, 32'hAA00BB00);
      tick();
      check("lat_second_edge", o_data_a, 32'hDE22BE44);
`else
      check("lat_first_edge", o_data_a, 32'hDE22BE44);
`endif
      i_addr_a = 8'h30;
      repeat (3) tick();
      check("hold_en_low", o_data_a, 32'hDE22BE44);

      // Reset mid-operation, then again 100 cycles into the clear.
      rst      = 1'b1;
      i_en_a   = 1'b1;
      i_we_a   = 4'hF;
      i_addr_a = 8'h50;
      i_data_a = 32'h55555555;
      tick();
      check("midop_rst_busy", {31'b0, o_busy}, 32'd1);
      check("midop_rst_data_a", o_data_a, 32'h0);
      check("midop_rst_data_b", o_data_b, 32'h0);
      rst = 1'b0;
      begin
         int not_busy;
         not_busy = 0;
         for (int c = 0; c < 100; c++) begin
            drive_junk();
            tick();
            if (o_busy !== 1'b1) not_busy++;
         end
         check("partial_clear_busy", 32'(not_busy), 32'd0);
      end
      rst = 1'b1;
      tick();
      check("reclear_rst_busy", {31'b0, o_busy}, 32'd1);
      rst = 1'b0;
      run_clear("reclear");
      read_all_zero("reclear");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
